// File: rtl/config_onchip_mem_arbiter_pkg.sv
// rtl/config_onchip_mem_arbiter_pkg.sv - shared constants and types for the on-chip RAM arbiter
package config_mem_arb_pkg;

    localparam int MEM_AW    = 14;
    localparam int MEM_DW    = 32;
    localparam int MEM_DEPTH = 10000;

    typedef logic mst_idx_t;

    typedef struct packed {
        logic [MEM_AW-1:0]   address;
        logic [MEM_DW/8-1:0] byteenable;
        logic                write;
        logic [MEM_DW-1:0]   writedata;
    } mem_req_t;

endpackage

// File: rtl/config_onchip_mem_arbiter_if.sv
// rtl/config_onchip_mem_arbiter_if.sv - Avalon-MM master bundle seen by the arbiter
interface config_onchip_mem_arbiter_if #(
    parameter int AW = config_mem_arb_pkg::MEM_AW,
    parameter int DW = config_mem_arb_pkg::MEM_DW
);
    logic [AW-1:0]   address;
    logic [DW/8-1:0] byteenable;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;
    logic            waitrequest;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/config_onchip_mem_arbiter_rr_arb2.sv
// rtl/config_onchip_mem_arbiter_rr_arb2.sv - two-way round-robin grant with last-winner register
module rr_arb2
    import config_mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output mst_idx_t idx_o,
    output logic     any_o
);

    mst_idx_t last_q;
    mst_idx_t last_d;
    mst_idx_t idx;
    logic     any;

    // Nothing is granted while reset is high so held-off masters see waitrequest.
    always_comb begin
        any    = (|req_i) & ~reset;
        idx    = 1'b1;
        if (&req_i) begin
            idx = ~last_q;
        end else if (req_i[0]) begin
            idx = 1'b0;
        end
        gnt_o  = 2'b00;
        if (any) begin
            gnt_o[idx] = 1'b1;
        end
        last_d = any ? idx : last_q;
        idx_o  = idx;
        any_o  = any;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/config_onchip_mem_arbiter.sv
// rtl/config_onchip_mem_arbiter.sv - two-master round-robin arbiter for the single-port on-chip RAM
// Optional out-of-range protection enabled by defining ARB_BOUNDS_CHECK_EN.
module config_onchip_mem_arbiter
    import config_mem_arb_pkg::*;
#(
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW,
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    config_onchip_mem_arbiter_if.slave m0,
    config_onchip_mem_arbiter_if.slave m1,
    output logic [AW-1:0]             mem_address,
    output logic [DW/8-1:0]           mem_byteenable,
    output logic [DW-1:0]             mem_writedata,
    output logic                      mem_chipselect,
    output logic                      mem_write,
    output logic                      mem_clken,
    input  logic [DW-1:0]             mem_readdata,
    output logic                      err
);

    logic [1:0] req;
    logic [1:0] gnt;
    mst_idx_t   gnt_idx;
    logic       gnt_any;
    mem_req_t   sel;
    logic       sel_oob;
    logic [DW-1:0] rd_data;

    logic     rd_pend_q, rd_pend_d;
    mst_idx_t rd_own_q,  rd_own_d;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i (req),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // A write strobe wins over a simultaneous read strobe.
    always_comb begin
        sel = '0;
        if (gnt_idx == 1'b0) begin
            sel.address    = m0.address;
            sel.byteenable = m0.byteenable;
            sel.write      = m0.write;
            sel.writedata  = m0.writedata;
        end else begin
            sel.address    = m1.address;
            sel.byteenable = m1.byteenable;
            sel.write      = m1.write;
            sel.writedata  = m1.writedata;
        end
    end

    assign m0.waitrequest = req[0] & ~gnt[0];
    assign m1.waitrequest = req[1] & ~gnt[1];

    assign mem_address    = sel.address;
    assign mem_byteenable = sel.byteenable;
    assign mem_writedata  = sel.writedata;
    assign mem_chipselect = gnt_any & ~sel_oob;
    assign mem_write      = mem_chipselect & sel.write;
    assign mem_clken      = ~reset;

    assign rd_pend_d = gnt_any & ~sel.write;
    assign rd_own_d  = gnt_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_own_q  <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
        end
    end

`ifdef ARB_BOUNDS_CHECK_EN
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic rd_oob_q, rd_oob_d;
    logic err_q, err_d;

    // Out-of-range accesses are still granted but never reach the RAM.
    assign sel_oob  = gnt_any & ({1'b0, sel.address} >= DEPTH_W);
    assign rd_oob_d = sel_oob & ~sel.write;
    assign err_d    = err_q | sel_oob;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_oob_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rd_oob_q <= rd_oob_d;
            err_q    <= err_d;
        end
    end

    assign rd_data = rd_oob_q ? '0 : mem_readdata;
    assign err     = err_q;
`else
    logic [31:0] unused_depth;

    assign unused_depth = 32'(DEPTH);
    assign sel_oob      = 1'b0;
    assign rd_data      = mem_readdata;
    assign err          = 1'b0;
`endif

    // Data is broadcast; only the valid strobe identifies the owner.
    assign m0.readdata      = rd_data;
    assign m1.readdata      = rd_data;
    assign m0.readdatavalid = rd_pend_q & ~reset & (rd_own_q == 1'b0);
    assign m1.readdatavalid = rd_pend_q & ~reset & (rd_own_q == 1'b1);

endmodule
